// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC transmit path.
package tdc_pkg;

   localparam int unsigned MEAS_W     = 40;
   localparam logic [7:0]  STATUS_TAG = 8'hA5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_WAIT_DONE
   } tx_state_t;

   function automatic logic [MEAS_W-1:0] status_word(input logic [15:0] drops,
                                                     input logic [15:0] frames);
      return {STATUS_TAG, drops, frames};
   endfunction

endpackage

// File: rtl/tdc_meas_fifo.sv
// Synchronous measurement FIFO; head word is visible combinationally on dout.
module tdc_meas_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 40
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign full  = (r_level == (AW+1)'(DEPTH));
   assign empty = (r_level == '0);
   assign level = r_level;
   assign dout  = r_mem[r_rd_ptr];

   // A push into a full FIFO still lands when the head leaves in the same cycle.
   assign w_pop_ok  = pop & ~empty;
   assign w_push_ok = push & (~full | w_pop_ok);

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/tdc_tx_scheduler.sv
// Owns the UART link: buffers measurements, interleaves periodic status frames,
// and enforces a minimum spacing between frame starts.
module tdc_tx_scheduler
   import tdc_pkg::*;
#(
   parameter int unsigned CLK_FREQ        = 100_000_000,
   parameter int unsigned TX_RATE_HZ      = 20,
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter int unsigned STATUS_INTERVAL = 100_000_000
) (
   input  logic                          clk_100m,
   input  logic                          rst_n,
   input  logic [MEAS_W-1:0]             meas_in,
   input  logic                          meas_valid,
   input  logic                          uart_busy,
   output logic [MEAS_W-1:0]             tx_data,
   output logic                          tx_kind,
   output logic                          tx_start,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [15:0]                   drop_count
);

   localparam int unsigned SLOT   = CLK_FREQ / TX_RATE_HZ;
   localparam int unsigned SLOT_W = $clog2(SLOT + 1);
   localparam int unsigned TMR_W  = (STATUS_INTERVAL > 1) ? $clog2(STATUS_INTERVAL) : 1;

   localparam logic [SLOT_W-1:0] SLOT_MAX   = SLOT_W'(SLOT);
   localparam logic [SLOT_W-1:0] SLOT_READY = SLOT_W'(SLOT - 1);
   localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(STATUS_INTERVAL - 1);

   tx_state_t           r_state;
   tx_state_t           w_next_state;
   logic [SLOT_W-1:0]   r_slot_cnt;
   logic [TMR_W-1:0]    r_timer;
   logic                r_status_due;
   logic [MEAS_W-1:0]   r_tx_data;
   logic                r_tx_kind;
   logic [15:0]         r_frames_sent;
   logic [15:0]         r_drop_count;

   logic                w_slot_ok;
   logic                w_select;
   logic                w_sel_status;
   logic                w_pop;
   logic                w_tx_start;
   logic                w_wrap;
   logic                w_drop;
   logic [MEAS_W-1:0]   w_fifo_head;
   logic                w_fifo_full;
   logic                w_fifo_empty;

   tdc_meas_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (MEAS_W)
   ) u_fifo (
      .clk   (clk_100m),
      .rst_n (rst_n),
      .push  (meas_valid),
      .pop   (w_pop),
      .din   (meas_in),
      .dout  (w_fifo_head),
      .full  (w_fifo_full),
      .empty (w_fifo_empty),
      .level (fifo_level)
   );

   // The counter reads 0 during the tx_start cycle; selecting at SLOT-1 puts
   // the next start exactly SLOT cycles after the previous one.
   assign w_slot_ok = (r_slot_cnt >= SLOT_READY);
   assign w_pop     = w_select & ~w_sel_status;
   assign w_wrap    = (r_timer == TMR_LAST);
   assign w_drop    = meas_valid & w_fifo_full & ~w_pop;

   always_comb begin
      w_next_state = r_state;
      w_select     = 1'b0;
      w_sel_status = 1'b0;
      w_tx_start   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_slot_ok && !uart_busy && (r_status_due || !w_fifo_empty)) begin
               w_select     = 1'b1;
               w_sel_status = r_status_due;
               w_next_state = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_tx_start   = 1'b1;
            w_next_state = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (uart_busy) w_next_state = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (!uart_busy) w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_slot_cnt    <= SLOT_MAX;
         r_timer       <= '0;
         r_status_due  <= 1'b0;
         r_tx_data     <= '0;
         r_tx_kind     <= 1'b0;
         r_frames_sent <= '0;
         r_drop_count  <= '0;
      end else begin
         r_state <= w_next_state;

         if (w_select) begin
            r_slot_cnt <= '0;
         end else if (r_slot_cnt != SLOT_MAX) begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
         end

         r_timer <= w_wrap ? '0 : r_timer + 1'b1;

         // A wrap landing on the selection cycle re-arms the request.
         if (w_wrap) begin
            r_status_due <= 1'b1;
         end else if (w_sel_status) begin
            r_status_due <= 1'b0;
         end

         if (w_select) begin
            r_tx_kind <= w_sel_status;
            r_tx_data <= w_sel_status ? status_word(r_drop_count, r_frames_sent) : w_fifo_head;
         end

         if (w_pop) r_frames_sent <= r_frames_sent + 1'b1;

         if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 1'b1;
         end
      end
   end

   assign tx_start   = w_tx_start;
   assign tx_data    = r_tx_data;
   assign tx_kind    = r_tx_kind;
   assign drop_count = r_drop_count;

endmodule

// File: tb/tb_tdc_tx_scheduler.sv
// Bench for tdc_tx_scheduler: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tdc_tx_scheduler;

   localparam int unsigned CLK_FREQ        = 1000;
   localparam int unsigned TX_RATE_HZ      = 10;
   localparam int unsigned FIFO_DEPTH      = 4;
   localparam int unsigned STATUS_INTERVAL = 500;
   localparam int          SLOT            = CLK_FREQ / TX_RATE_HZ;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b0;
   logic [39:0] meas_in    = '0;
   logic        meas_valid = 1'b0;
   logic        uart_busy  = 1'b0;
   logic [39:0] tx_data;
   logic        tx_kind;
   logic        tx_start;
   logic [2:0]  fifo_level;
   logic [15:0] drop_count;

   always #5 clk = ~clk;

   tdc_tx_scheduler #(
      .CLK_FREQ        (CLK_FREQ),
      .TX_RATE_HZ      (TX_RATE_HZ),
      .FIFO_DEPTH      (FIFO_DEPTH),
      .STATUS_INTERVAL (STATUS_INTERVAL)
   ) dut (
      .clk_100m   (clk),
      .rst_n      (rst_n),
      .meas_in    (meas_in),
      .meas_valid (meas_valid),
      .uart_busy  (uart_busy),
      .tx_data    (tx_data),
      .tx_kind    (tx_kind),
      .tx_start   (tx_start),
      .fifo_level (fifo_level),
      .drop_count (drop_count)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // UART stand-in: busy rises the cycle after tx_start and lasts busy_len cycles.
   int   busy_len   = 20;
   int   busy_cnt   = 0;
   logic force_busy = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)             busy_cnt = 0;
      else if (tx_start)      busy_cnt = busy_len;
      else if (busy_cnt > 0)  busy_cnt--;
   end

   always @(posedge clk) begin
      #2;
      uart_busy = force_busy || (busy_cnt > 0);
   end

   // Reference model: FIFO as a queue, frame starts at least SLOT cycles apart,
   // status requested every STATUS_INTERVAL cycles after reset.
   logic [39:0]  mq[$];
   int unsigned  m_drops      = 0;
   logic [15:0]  m_frames     = '0;
   bit           m_due        = 0;
   bit           m_start      = 0;
   int           m_link       = 0;   // 0 free, 1 awaiting busy, 2 awaiting idle
   longint       m_cyc        = 0;
   longint       m_last_issue = -SLOT;
   longint       m_edges      = 0;
   logic [39:0]  m_data       = '0;
   bit           m_kind       = 0;

   always @(posedge clk or negedge rst_n) begin
      bit sel;
      if (!rst_n) begin
         mq.delete();
         m_drops = 0; m_frames = '0; m_due = 0; m_start = 0; m_link = 0;
         m_cyc = 0; m_last_issue = -SLOT; m_edges = 0; m_data = '0; m_kind = 0;
      end else begin
         sel = !m_start && (m_link == 0) && !uart_busy &&
               (m_cyc - m_last_issue >= SLOT - 1) && (m_due || mq.size() > 0);
         if (m_start) begin
            m_last_issue = m_cyc;
            m_link       = 1;
         end else if (m_link == 1 && uart_busy) begin
            m_link = 2;
         end else if (m_link == 2 && !uart_busy) begin
            m_link = 0;
         end
         if (sel) begin
            if (m_due) begin
               m_data = {8'hA5, m_drops[15:0], m_frames};
               m_kind = 1;
               m_due  = 0;
            end else begin
               m_data = mq.pop_front();
               m_kind = 0;
               m_frames++;
            end
         end
         if (meas_valid) begin
            if (mq.size() < FIFO_DEPTH) mq.push_back(meas_in);
            else if (m_drops < 65535)   m_drops++;
         end
         m_edges++;
         if (m_edges % STATUS_INTERVAL == 0) m_due = 1;
         m_start = sel;
         m_cyc++;
      end
   end

   always @(negedge clk) begin
      check("tx_start",   tx_start,   m_start);
      check("tx_kind",    tx_kind,    m_kind);
      check("tx_data",    tx_data,    m_data);
      check("fifo_level", fifo_level, mq.size());
      check("drop_count", drop_count, m_drops);
   end

   // Frame log for the directed scenarios.
   int          cyc_no = 0;
   logic [39:0] fr_data[$];
   bit          fr_kind[$];
   int          fr_cyc[$];

   always @(posedge clk) cyc_no++;

   always @(negedge clk) begin
      if (rst_n && tx_start) begin
         fr_data.push_back(tx_data);
         fr_kind.push_back(tx_kind);
         fr_cyc.push_back(cyc_no);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_frames();
      fr_data.delete();
      fr_kind.delete();
      fr_cyc.delete();
   endtask

   task automatic do_reset();
      meas_valid = 1'b0;
      force_busy = 1'b0;
      busy_len   = 20;
      rst_n      = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      clr_frames();
   endtask

   task automatic push_word(input logic [39:0] w);
      meas_valid = 1'b1;
      meas_in    = w;
      tick();
      meas_valid = 1'b0;
   endtask

   task automatic wait_frames(input int n, input int limit, input string name);
      int k = 0;
      while (fr_data.size() < n && k < limit) begin
         tick();
         k++;
      end
      if (fr_data.size() < n) check(name, fr_data.size(), n);
   endtask

   int          rate;
   logic [63:0] rnd;

   initial begin
      // 1: latency from meas_valid to tx_start
      do_reset();
      meas_valid = 1'b1;
      meas_in    = 40'h12_3456_789A;
      #3;
      check("t1_start_c0", tx_start, 0);
      tick();
      meas_valid = 1'b0;
      check("t1_start_c1", tx_start, 0);
      tick();
      check("t1_start_c2", tx_start, 1);
      check("t1_data",     tx_data,  40'h12_3456_789A);
      check("t1_kind",     tx_kind,  0);
      tick();
      check("t1_start_c3", tx_start, 0);

      // 2: start spacing equals SLOT
      do_reset();
      for (int i = 0; i < 3; i++) push_word(40'h20_0000_0000 + 40'(i));
      wait_frames(3, 400, "t2_timeout");
      if (fr_data.size() >= 3) begin
         check("t2_gap1",  fr_cyc[1] - fr_cyc[0], 100);
         check("t2_gap2",  fr_cyc[2] - fr_cyc[1], 100);
         check("t2_data0", fr_data[0], 40'h20_0000_0000);
         check("t2_data1", fr_data[1], 40'h20_0000_0001);
         check("t2_data2", fr_data[2], 40'h20_0000_0002);
      end

      // 3+4: overflow drops, then push while full in the popping cycle
      do_reset();
      force_busy = 1'b1;
      for (int i = 1; i <= 7; i++) push_word(40'h30_0000_0000 + 40'(i));
      repeat (2) tick();
      check("t3_level", fifo_level, 4);
      check("t3_drops", drop_count, 3);
      force_busy = 1'b0;
      meas_valid = 1'b1;
      meas_in    = 40'h30_0000_0008;
      tick();
      meas_valid = 1'b0;
      check("t4_drops", drop_count, 3);
      check("t4_level", fifo_level, 4);
      wait_frames(5, 600, "t3_timeout");
      if (fr_data.size() >= 5) begin
         for (int i = 0; i < 4; i++) check("t3_order", fr_data[i], 40'h30_0000_0001 + 40'(i));
         check("t4_last", fr_data[4], 40'h30_0000_0008);
      end

      // 5: status frame wins over a non-empty FIFO
      do_reset();
      force_busy = 1'b1;
      repeat (480) tick();
      for (int i = 0; i < 6; i++) push_word(40'h50_0000_0000 + 40'(i));
      repeat (30) tick();
      force_busy = 1'b0;
      wait_frames(2, 300, "t5_timeout");
      if (fr_data.size() >= 2) begin
         check("t5_kind0", fr_kind[0], 1);
         check("t5_data0", fr_data[0], 40'hA5_0002_0000);
         check("t5_kind1", fr_kind[1], 0);
         check("t5_data1", fr_data[1], 40'h50_0000_0000);
      end

      // 6: reset during WAIT_DONE
      do_reset();
      push_word(40'h60_0000_00AA);
      push_word(40'h60_0000_00BB);
      push_word(40'h60_0000_00CC);
      wait_frames(1, 50, "t6_timeout");
      repeat (5) tick();
      check("t6_level_pre", fifo_level, 2);
      rst_n = 1'b0;
      #1;
      check("t6_rst_start", tx_start,   0);
      check("t6_rst_data",  tx_data,    0);
      check("t6_rst_kind",  tx_kind,    0);
      check("t6_rst_level", fifo_level, 0);
      check("t6_rst_drops", drop_count, 0);
      repeat (2) tick();
      rst_n      = 1'b1;
      meas_valid = 1'b1;
      meas_in    = 40'h60_0000_00DD;
      tick();
      meas_valid = 1'b0;
      check("t6_post_c1", tx_start, 0);
      tick();
      check("t6_post_c2", tx_start, 1);
      check("t6_post_data", tx_data, 40'h60_0000_00DD);

      // Randomized traffic against the model
      do_reset();
      for (int seg = 0; seg < 8; seg++) begin
         rate       = $urandom_range(0, 8);
         force_busy = ($urandom_range(0, 3) == 0);
         for (int c = 0; c < 500; c++) begin
            busy_len   = $urandom_range(1, 70);
            meas_valid = ($urandom_range(0, 99) < rate);
            rnd        = {$urandom, $urandom};
            meas_in    = rnd[39:0];
            if (seg == 5 && c == 250) begin
               rst_n = 1'b0;
               tick();
               tick();
               rst_n = 1'b1;
            end
            tick();
         end
      end
      meas_valid = 1'b0;
      force_busy = 1'b0;
      repeat (5) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
